// File: rtl/mem_serializer_pipelined.sv
// Wide-to-narrow memory request serializer: splits a line access into narrow
// word accesses, keeping up to MAX_PENDING reads in flight and reassembling the line.

module mem_serializer_lane #(
  parameter int OUT_W = 32,
  parameter int OB    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_we,
  input  logic [OUT_W-1:0] i_wdata,
  input  logic [OB-1:0]    i_byteen,
  output logic [OUT_W-1:0] o_word,
  output logic             o_mask
);
  logic [OUT_W-1:0] r_word;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_word <= '0;
    else if (i_we) r_word <= i_wdata;
  end

  assign o_word = r_word;
  assign o_mask = |i_byteen;
endmodule

module mem_serializer_pipelined #(
  parameter int ADDR_WIDTH_BIT     = 32,
  parameter int IN_DATA_WIDTH_BIT  = 128,
  parameter int OUT_DATA_WIDTH_BIT = 32,
  parameter int TAG_WIDTH_BIT      = 1,
  parameter int MAX_PENDING        = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_req_valid,
  output logic                            in_req_ready,
  input  logic                            in_req_rw,
  input  logic [IN_DATA_WIDTH_BIT/8-1:0]  in_req_byteen,
  input  logic [ADDR_WIDTH_BIT-1:0]       in_req_addr,
  input  logic [IN_DATA_WIDTH_BIT-1:0]    in_req_data,
  input  logic [TAG_WIDTH_BIT-1:0]        in_req_tag,
  output logic                            in_rsp_valid,
  input  logic                            in_rsp_ready,
  output logic [IN_DATA_WIDTH_BIT-1:0]    in_rsp_data,
  output logic [TAG_WIDTH_BIT-1:0]        in_rsp_tag,
  output logic                            out_req_valid,
  input  logic                            out_req_ready,
  output logic                            out_req_rw,
  output logic [OUT_DATA_WIDTH_BIT/8-1:0] out_req_byteen,
  output logic [ADDR_WIDTH_BIT+$clog2(IN_DATA_WIDTH_BIT/OUT_DATA_WIDTH_BIT)+$clog2(OUT_DATA_WIDTH_BIT/8)-1:0] out_req_addr,
  output logic [OUT_DATA_WIDTH_BIT-1:0]   out_req_data,
  output logic [TAG_WIDTH_BIT-1:0]        out_req_tag,
  input  logic                            out_rsp_valid,
  output logic                            out_rsp_ready,
  input  logic [OUT_DATA_WIDTH_BIT-1:0]   out_rsp_data
);
  localparam int RATIO  = IN_DATA_WIDTH_BIT / OUT_DATA_WIDTH_BIT;
  localparam int IB     = IN_DATA_WIDTH_BIT / 8;
  localparam int OB     = OUT_DATA_WIDTH_BIT / 8;
  localparam int LOG_R  = $clog2(RATIO);
  localparam int IW     = (LOG_R > 0) ? LOG_R : 1;
  localparam int LOG_OB = $clog2(OB);
  localparam int OAW    = ADDR_WIDTH_BIT + LOG_R + LOG_OB;
  localparam int PW     = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_RESP} state_t;

  state_t                       r_state;
  logic                         r_rw;
  logic [ADDR_WIDTH_BIT-1:0]    r_addr;
  logic [TAG_WIDTH_BIT-1:0]     r_tag;
  logic [IN_DATA_WIDTH_BIT-1:0] r_data;
  logic [IB-1:0]                r_byteen;
  logic [RATIO-1:0]             r_mask;
  logic [PW-1:0]                r_pend;
  logic [IW-1:0]                r_rsp_idx;

  logic [RATIO-1:0]                         w_in_mask, w_mask_nxt, w_lane_we;
  logic [RATIO-1:0][OUT_DATA_WIDTH_BIT-1:0] w_line, w_data_words;
  logic [RATIO-1:0][OB-1:0]                 w_be_words;
  logic [IW-1:0]                            w_idx;
  logic w_req_hs, w_rsp_hs, w_last_rsp, w_pend_full;

  // One lane per narrow word: owns its slice of the response line buffer.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    assign w_lane_we[g] = w_rsp_hs && (r_rsp_idx == IW'(g));
    mem_serializer_lane #(.OUT_W(OUT_DATA_WIDTH_BIT), .OB(OB)) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_we     (w_lane_we[g]),
      .i_wdata  (out_rsp_data),
      .i_byteen (in_req_byteen[g*OB +: OB]),
      .o_word   (w_line[g]),
      .o_mask   (w_in_mask[g])
    );
  end

  always_comb begin
    w_idx = '0;
    for (int i = RATIO-1; i >= 0; i--)
      if (r_mask[i]) w_idx = IW'(i);
  end

  assign w_mask_nxt   = r_mask & (r_mask - RATIO'(1));
  assign w_data_words = r_data;
  assign w_be_words   = r_byteen;

  assign w_pend_full = (r_pend == PW'(MAX_PENDING));
  assign w_rsp_hs    = out_rsp_valid && out_rsp_ready;
  assign w_req_hs    = out_req_valid && out_req_ready;
  assign w_last_rsp  = w_rsp_hs && (r_rsp_idx == IW'(RATIO-1));

  // A response retiring this cycle frees a slot, so a full window may still issue.
  assign out_req_valid  = (r_state == ST_ISSUE) && (r_mask != '0) && (!w_pend_full || w_rsp_hs);
  assign out_rsp_ready  = (r_pend != '0);
  assign in_req_ready   = (r_state == ST_IDLE) && !rst_i;
  assign in_rsp_valid   = (r_state == ST_RESP);
  assign in_rsp_data    = w_line;
  assign in_rsp_tag     = r_tag;
  assign out_req_rw     = r_rw;
  assign out_req_tag    = r_tag;
  assign out_req_data   = w_data_words[w_idx];
  assign out_req_byteen = w_be_words[w_idx];
  assign out_req_addr   = (OAW'(r_addr) << (LOG_R + LOG_OB)) | (OAW'(w_idx) << LOG_OB);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_tag     <= '0;
      r_data    <= '0;
      r_byteen  <= '0;
      r_mask    <= '0;
      r_pend    <= '0;
      r_rsp_idx <= '0;
    end else begin
      if (w_req_hs) r_mask <= w_mask_nxt;
      if (!r_rw)    r_pend <= r_pend + PW'(w_req_hs) - PW'(w_rsp_hs);
      if (w_rsp_hs) r_rsp_idx <= r_rsp_idx + IW'(1);
      case (r_state)
        ST_IDLE: if (in_req_valid) begin
          r_rw      <= in_req_rw;
          r_addr    <= in_req_addr;
          r_tag     <= in_req_tag;
          r_data    <= in_req_data;
          r_byteen  <= in_req_rw ? in_req_byteen : '1;
          r_mask    <= in_req_rw ? w_in_mask : '1;
          r_pend    <= '0;
          r_rsp_idx <= '0;
          r_state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (r_mask == '0)                      r_state <= ST_IDLE;
          else if (w_last_rsp)                   r_state <= ST_RESP;
          else if (w_req_hs && w_mask_nxt == '0) r_state <= r_rw ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: if (w_last_rsp)   r_state <= ST_RESP;
        ST_RESP:  if (in_rsp_ready) r_state <= ST_IDLE;
        default:                    r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_serializer_pipelined.sv
// Scoreboard bench: stimulus pushes expected narrow requests and wide lines;
// a narrow-side memory responder/monitor pops and compares.

module tb_mem_serializer_pipelined;
  logic         clk_i, rst_i;
  logic         in_req_valid, in_req_ready, in_req_rw;
  logic [15:0]  in_req_byteen;
  logic [31:0]  in_req_addr;
  logic [127:0] in_req_data;
  logic         in_req_tag;
  logic         in_rsp_valid, in_rsp_ready;
  logic [127:0] in_rsp_data;
  logic         in_rsp_tag;
  logic         out_req_valid, out_req_ready, out_req_rw;
  logic [3:0]   out_req_byteen;
  logic [35:0]  out_req_addr;
  logic [31:0]  out_req_data;
  logic         out_req_tag;
  logic         out_rsp_valid, out_rsp_ready;
  logic [31:0]  out_rsp_data;

  mem_serializer_pipelined dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
    .in_req_byteen(in_req_byteen), .in_req_addr(in_req_addr), .in_req_data(in_req_data),
    .in_req_tag(in_req_tag),
    .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req_rw(out_req_rw),
    .out_req_byteen(out_req_byteen), .out_req_addr(out_req_addr), .out_req_data(out_req_data),
    .out_req_tag(out_req_tag),
    .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready), .out_rsp_data(out_rsp_data)
  );

  typedef struct { logic rw; logic [35:0] addr; logic [3:0] be; logic [31:0] data; logic tag; } nreq_t;
  typedef struct { logic [127:0] data; logic tag; } wrsp_t;

  nreq_t       exp_req[$];
  wrsp_t       exp_rsp[$];
  logic [35:0] rfifo[$];
  logic [31:0] mem [bit [35:0]];

  int n_vec = 0, n_err = 0;
  int n_req = 0, n_rsp = 0, n_dual = 0;
  int rsp_limit = -1;
  bit all_rdy = 0, bogus_rsp = 0;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] get_word(input logic [35:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Narrow-side memory model plus monitor for both output channels.
  logic         prev_req_stall = 0, prev_rsp_stall = 0;
  logic [35:0]  prev_addr;
  logic [31:0]  prev_data;
  logic [127:0] prev_line;
  initial begin
    logic rsp_hs, req_hs;
    nreq_t e;
    wrsp_t w;
    out_req_ready = 0; out_rsp_valid = 0; out_rsp_data = '0; in_rsp_ready = 0;
    forever begin
      @(posedge clk_i); #1;
      out_req_ready = all_rdy || ($urandom_range(3) != 0);
      in_rsp_ready  = all_rdy || ($urandom_range(2) != 0);
      if (bogus_rsp) begin
        out_rsp_valid = 1; out_rsp_data = 32'hDEADBEEF;
      end else if (rfifo.size() != 0 && (rsp_limit < 0 || n_rsp < rsp_limit) &&
                   (all_rdy || $urandom_range(3) != 0)) begin
        out_rsp_valid = 1; out_rsp_data = get_word(rfifo[0]);
      end else begin
        out_rsp_valid = 0; out_rsp_data = $urandom;
      end
      @(negedge clk_i);
      if (rst_i) begin
        rfifo.delete(); exp_req.delete(); exp_rsp.delete();
        prev_req_stall = 0; prev_rsp_stall = 0;
      end else begin
        rsp_hs = out_rsp_valid && out_rsp_ready;
        req_hs = out_req_valid && out_req_ready;
        if (rsp_hs && req_hs) n_dual++;
        if (rsp_hs) begin
          n_rsp++;
          if (rfifo.size() != 0) void'(rfifo.pop_front());
        end
        if (prev_req_stall) begin
          chk("oreq_hold_valid", out_req_valid, 1'b1);
          chk("oreq_hold_addr", out_req_addr, prev_addr);
          chk("oreq_hold_data", out_req_data, prev_data);
        end
        if (prev_rsp_stall) begin
          chk("irsp_hold_valid", in_rsp_valid, 1'b1);
          chk("irsp_hold_data", in_rsp_data, prev_line);
        end
        prev_req_stall = out_req_valid && !out_req_ready;
        prev_addr = out_req_addr; prev_data = out_req_data;
        prev_rsp_stall = in_rsp_valid && !in_rsp_ready;
        prev_line = in_rsp_data;
        if (req_hs) begin
          n_req++;
          if (exp_req.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL oreq_unexpected: got addr %0h, want no request", out_req_addr);
          end else begin
            e = exp_req.pop_front();
            chk("oreq_rw", out_req_rw, e.rw);
            chk("oreq_addr", out_req_addr, e.addr);
            chk("oreq_byteen", out_req_byteen, e.be);
            chk("oreq_tag", out_req_tag, e.tag);
            if (e.rw) chk("oreq_data", out_req_data, e.data);
          end
          if (!out_req_rw) rfifo.push_back(out_req_addr);
        end
        if (in_rsp_valid && in_rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL irsp_unexpected: got line %0h, want no response", in_rsp_data);
          end else begin
            w = exp_rsp.pop_front();
            chk("irsp_data", in_rsp_data, w.data);
            chk("irsp_tag", in_rsp_tag, w.tag);
          end
        end
      end
    end
  end

  task automatic issue(input logic rw, input logic [31:0] a, input logic [15:0] be,
                       input logic [127:0] d, input logic tag);
    nreq_t e;
    logic [127:0] line;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      e.rw = rw; e.addr = {a, i[1:0], 2'b00};
      e.be = rw ? be[i*4 +: 4] : 4'hF;
      e.data = d[i*32 +: 32]; e.tag = tag;
      if (!rw || e.be != 0) exp_req.push_back(e);
      line[i*32 +: 32] = get_word(e.addr);
    end
    if (!rw) exp_rsp.push_back('{line, tag});
    @(posedge clk_i); #1;
    in_req_valid = 1; in_req_rw = rw; in_req_addr = a; in_req_byteen = be;
    in_req_data = d; in_req_tag = tag;
    cyc = 0;
    forever begin
      @(negedge clk_i);
      if (in_req_ready) break;
      if (++cyc > 2000) begin
        n_vec++; n_err++;
        $display("FAIL in_req_timeout: got ready=0, want ready=1");
        break;
      end
    end
    @(posedge clk_i); #1;
    in_req_valid = 0; in_req_addr = $urandom; in_req_rw = $urandom_range(1);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    forever begin
      @(negedge clk_i);
      if (in_req_ready && exp_req.size() == 0 && exp_rsp.size() == 0) break;
      if (++cyc > 3000) begin
        n_vec++; n_err++;
        $display("FAIL idle_timeout: got %0d reqs %0d lines pending, want 0", exp_req.size(), exp_rsp.size());
        break;
      end
    end
  endtask

  task automatic wait_req(input int target);
    int cyc = 0;
    while (n_req < target) begin
      @(negedge clk_i);
      if (++cyc > 500) begin
        n_vec++; n_err++;
        $display("FAIL req_count_timeout: got %0d want %0d", n_req, target);
        break;
      end
    end
  endtask

  initial begin
    int r0, d0;
    logic [15:0] be;
    logic [127:0] d;
    rst_i = 1; in_req_valid = 0; in_req_rw = 0; in_req_byteen = '0;
    in_req_addr = '0; in_req_data = '0; in_req_tag = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_in_req_ready", in_req_ready, 1'b0);
    chk("rst_out_req_valid", out_req_valid, 1'b0);
    chk("rst_in_rsp_valid", in_rsp_valid, 1'b0);
    chk("rst_out_rsp_ready", out_rsp_ready, 1'b0);
    @(posedge clk_i); #1 rst_i = 0;
    @(negedge clk_i);
    chk("rel_in_req_ready", in_req_ready, 1'b1);

    // Directed line read with known memory contents.
    all_rdy = 1;
    for (int i = 0; i < 4; i++) mem[36'h100 + 36'(4*i)] = 32'hA0 + 32'(i);
    issue(0, 32'h10, '1, '0, 1);
    wait_idle();

    // Sparse write: words 1 and 3 only.
    r0 = n_req;
    d = {$urandom, $urandom, $urandom, $urandom};
    issue(1, $urandom, 16'hF0F0, d, 0);
    wait_idle();
    chk("wr_f0f0_count", n_req - r0, 2);

    // Fully masked write: no narrow traffic, ready again two cycles later.
    r0 = n_req;
    issue(1, $urandom, 16'h0000, d, 1);
    @(negedge clk_i);
    chk("wr0_busy", in_req_ready, 1'b0);
    chk("wr0_no_oreq", out_req_valid, 1'b0);
    @(negedge clk_i);
    chk("wr0_ready", in_req_ready, 1'b1);
    chk("wr0_count", n_req - r0, 0);

    // Withheld responses cap the outstanding window.
    r0 = n_req; rsp_limit = n_rsp;
    issue(0, $urandom, '1, '0, 0);
    repeat (10) @(negedge clk_i);
    chk("window_count", n_req - r0, 2);
    chk("window_stall", out_req_valid, 1'b0);
    rsp_limit = -1;
    wait_idle();

    // Eager responder: request and response handshake together.
    d0 = n_dual;
    issue(0, $urandom, '1, '0, 1);
    wait_idle();
    chk("dual_hs", n_dual - d0, 3);

    // Reset while draining, then a stray response, then a clean read.
    r0 = n_req; rsp_limit = n_rsp;
    issue(0, $urandom, '1, '0, 1);
    wait_req(r0 + 2);
    rsp_limit = n_rsp + 2;
    wait_req(r0 + 4);
    repeat (2) @(negedge clk_i);
    chk("drain_rsp_ready", out_rsp_ready, 1'b1);
    @(posedge clk_i); #1 rst_i = 1;
    @(negedge clk_i);
    chk("mid_rst_in_req_ready", in_req_ready, 1'b0);
    chk("mid_rst_out_req_valid", out_req_valid, 1'b0);
    chk("mid_rst_in_rsp_valid", in_rsp_valid, 1'b0);
    chk("mid_rst_out_rsp_ready", out_rsp_ready, 1'b0);
    bogus_rsp = 1;
    @(posedge clk_i); #1 rst_i = 0; rsp_limit = -1;
    @(negedge clk_i);
    chk("stray_rsp_ready", out_rsp_ready, 1'b0);
    chk("post_rst_in_req_ready", in_req_ready, 1'b1);
    bogus_rsp = 0;
    issue(0, $urandom, '1, '0, 0);
    wait_idle();

    // Random traffic with random back-pressure.
    all_rdy = 0;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(3))
        0:       be = 16'h0000;
        1:       be = 16'hFFFF;
        default: be = 16'($urandom);
      endcase
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(1'($urandom_range(1)), $urandom, be, d, 1'($urandom_range(1)));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
